// File: rtl/bcd_counter_pkg.sv
// Shared types, 7-segment constants and the BCD-to-segment helper for the
// multi-digit BCD counter.
//   bcd_t      : one BCD digit (0..9 in normal operation)
//   seg_t      : active-low segments ordered {g,f,e,d,c,b,a}
//   bcd_to_seg : fixed decode for 0..9, blank for anything else
package bcd_counter_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    function automatic seg_t bcd_to_seg(input bcd_t d);
        seg_t s;
        s = SEG_BLANK;
        // Non-BCD codes cannot occur in normal operation; show a blank digit.
        if (d <= 4'd9) begin
            s = SEG_DIGIT[d];
        end
        return s;
    endfunction

endpackage

// File: rtl/bcd_seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder for one digit.
//   bcd_i : BCD digit
//   seg_o : active-low segments {g..a}
module bcd_seg7_decoder
    import bcd_counter_pkg::*;
(
    input  bcd_t bcd_i,
    output seg_t seg_o
);

    assign seg_o = bcd_to_seg(bcd_i);

endmodule

// File: rtl/bcd_multi_counter.sv
// N-digit BCD up/down counter with remainder-carrying tick prescaler,
// speed select, wrap/saturate mode, synchronous clear/load and registered
// active-low 7-segment outputs.
//   clk_i        : clock, all state on posedge
//   rst_ni       : asynchronous active-low reset
//   en_i         : 1 = run, 0 = pause (prescaler and digits hold)
//   up_i         : count direction, 1 = up
//   speed_i      : 00 x1, 01 x2, 10 x4, 11 x8
//   sat_i        : 1 = saturate at the boundary, 0 = wrap
//   clr_i        : synchronous clear (highest priority)
//   load_i       : synchronous preset load (nibbles above 9 clamp to 9)
//   load_val_i   : BCD preset, digit 0 in [3:0]
//   digits_o     : registered BCD count, digit 0 in [3:0]
//   hex_o        : registered segments, digit 0 in [6:0]
//   tick_o       : one-cycle pulse aligned with each new count step
//   tc_o         : one-cycle pulse when that step hit the boundary
module bcd_multi_counter
    import bcd_counter_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ    = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    up_i,
    input  logic [1:0]              speed_i,
    input  logic                    sat_i,
    input  logic                    clr_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] load_val_i,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [7*NUM_DIGITS-1:0] hex_o,
    output logic                    tick_o,
    output logic                    tc_o
);

    localparam int unsigned PERIOD = CLK_HZ / TICK_HZ;
    // Headroom so prescaler + 8 never overflows before the compare.
    localparam int unsigned PW     = $clog2(PERIOD) + 4;

    if (PERIOD < 8) begin : g_period_check
        $error("bcd_multi_counter: PERIOD = CLK_HZ/TICK_HZ must be at least 8");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_digits_check
        $error("bcd_multi_counter: NUM_DIGITS must be in 1..8");
    end

    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic                    tick_q, tick_d;
    logic                    tc_q, tc_d;

    logic [PW-1:0]           presc_inc;
    logic [PW-1:0]           presc_sum;
    logic                    presc_wrap;

    logic [4*NUM_DIGITS-1:0] stepped;
    logic [4*NUM_DIGITS-1:0] load_clamped;
    logic                    boundary;
    bcd_t                    cur;
    bcd_t                    nib;
    logic                    carry;

    // Prescaler: the remainder is kept on wrap so the average rate stays
    // exact even when inc does not divide PERIOD.
    always_comb begin
        presc_inc  = PW'(1) << speed_i;
        presc_sum  = presc_q + presc_inc;
        presc_wrap = (presc_sum >= PW'(PERIOD));
    end

    // Ripple step: a digit moves only while every lower digit is rolling over.
    // A carry out of the top digit marks the all-9s / all-0s boundary.
    always_comb begin
        stepped = digits_q;
        carry   = 1'b1;
        cur     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            cur = digits_q[4*k +: 4];
            if (carry) begin
                if (up_i) begin
                    if (cur == 4'd9) begin
                        stepped[4*k +: 4] = 4'd0;
                    end else begin
                        stepped[4*k +: 4] = cur + 4'd1;
                        carry             = 1'b0;
                    end
                end else begin
                    if (cur == 4'd0) begin
                        stepped[4*k +: 4] = 4'd9;
                    end else begin
                        stepped[4*k +: 4] = cur - 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
        boundary = carry;
    end

    always_comb begin
        load_clamped = '0;
        nib          = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib                    = load_val_i[4*k +: 4];
            load_clamped[4*k +: 4] = (nib > 4'd9) ? 4'd9 : nib;
        end
    end

    // Priority: clear, then load, then an enabled step.
    always_comb begin
        digits_d = digits_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;
        tc_d     = 1'b0;
        if (clr_i) begin
            digits_d = '0;
            presc_d  = '0;
        end else if (load_i) begin
            digits_d = load_clamped;
            presc_d  = '0;
        end else if (en_i) begin
            if (presc_wrap) begin
                presc_d = presc_sum - PW'(PERIOD);
                tick_d  = 1'b1;
                tc_d    = boundary;
                // A saturated step still pulses tick/tc but holds the digits.
                if (!(boundary && sat_i)) begin
                    digits_d = stepped;
                end
            end else begin
                presc_d = presc_sum;
            end
        end
    end

    // Decode the next value so hex updates on the same edge as digits.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        bcd_seg7_decoder u_dec (
            .bcd_i (digits_d[4*g +: 4]),
            .seg_o (hex_d[7*g +: 7])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digits_q <= '0;
            hex_q    <= {NUM_DIGITS{SEG_DIGIT[0]}};
            presc_q  <= '0;
            tick_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            digits_q <= digits_d;
            hex_q    <= hex_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            tc_q     <= tc_d;
        end
    end

    assign digits_o = digits_q;
    assign hex_o    = hex_q;
    assign tick_o   = tick_q;
    assign tc_o     = tc_q;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Self-checking bench for bcd_multi_counter with 2 digits and PERIOD = 10.
// Expected {tc, digits} per step are queued by the stimulus and popped by a
// monitor whenever the DUT pulses tick.
module tb_bcd_multi_counter;

    localparam int unsigned ND      = 2;
    localparam int          TIMEOUT = 200;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          up;
    logic [1:0]    speed;
    logic          sat;
    logic          clr;
    logic          load;
    logic [4*ND-1:0] load_val;
    logic [4*ND-1:0] digits;
    logic [7*ND-1:0] hex;
    logic          tick;
    logic          tc;

    int n_cmp;
    int n_err;
    logic [8:0] exp_q [$];
    logic [8:0] exp_e;

    bcd_multi_counter #(
        .NUM_DIGITS (ND),
        .CLK_HZ     (100),
        .TICK_HZ    (10)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .up_i       (up),
        .speed_i    (speed),
        .sat_i      (sat),
        .clr_i      (clr),
        .load_i     (load),
        .load_val_i (load_val),
        .digits_o   (digits),
        .hex_o      (hex),
        .tick_o     (tick),
        .tc_o       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns after the negedge on which the n-th tick is seen; cycles counts
    // negedges sampled, so a step on edge L+j after a load on edge L gives j+1.
    task automatic wait_ticks(input int n, output int cycles);
        int seen;
        seen   = 0;
        cycles = 0;
        while (seen < n && cycles < TIMEOUT) begin
            @(negedge clk);
            cycles++;
            if (tick) seen++;
        end
        if (seen < n) check("tick_timeout", seen, n);
    endtask

    task automatic do_load(input logic [4*ND-1:0] val);
        @(posedge clk);
        #1;
        load     = 1'b1;
        load_val = val;
        @(posedge clk);
        #1;
        load     = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tc && !tick) check("tc_without_tick", 1, 0);
            if (tick) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tick", {tc, digits}, 9'h1ff);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("step", {tc, digits}, exp_e);
                end
            end
        end
    end

    initial begin
        int c;
        int pause_ticks;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0; en = 1'b0; up = 1'b1; speed = 2'b00; sat = 1'b0;
        clr = 1'b0; load = 1'b0; load_val = '0;

        // Reset state
        #12;
        check("rst_digits", digits, 8'h00);
        check("rst_hex", hex, 14'h2040);
        check("rst_tick", tick, 0);
        check("rst_tc", tc, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // x1 up wrap: 98 -> 99 -> 00 (tc)
        en = 1'b1;
        do_load(8'h98);
        check("load_98", digits, 8'h98);
        exp_q.push_back(9'h099);
        exp_q.push_back(9'h100);
        wait_ticks(1, c);
        check("x1_first_latency", c, 11);
        wait_ticks(1, c);
        check("x1_period", c, 10);
        check("x1_wrap_hex", hex, 14'h2040);

        // x4 down with borrow and wrap to 99
        speed = 2'b10;
        up    = 1'b0;
        do_load(8'h10);
        for (int v = 9; v >= 0; v--) exp_q.push_back(9'(v));
        exp_q.push_back(9'h199);
        wait_ticks(10, c);
        check("x4_ten_steps", c, 26);
        wait_ticks(1, c);
        check("x4_gap", c, 3);

        // Saturate at 99
        speed = 2'b00;
        up    = 1'b1;
        sat   = 1'b1;
        do_load(8'h99);
        repeat (3) exp_q.push_back(9'h199);
        wait_ticks(3, c);
        check("sat_three_steps", c, 31);
        check("sat_hold", digits, 8'h99);

        // Load clamp, then clr+load on what would have been a step edge
        sat = 1'b0;
        do_load(8'hA5);
        check("clamp_digits", digits, 8'h95);
        check("clamp_hex", hex, 14'h0812);
        repeat (9) @(posedge clk);
        #1;
        clr      = 1'b1;
        load     = 1'b1;
        load_val = 8'h37;
        @(posedge clk);
        #1;
        clr  = 1'b0;
        load = 1'b0;
        check("clr_digits", digits, 8'h00);
        check("clr_no_tick", tick, 0);
        exp_q.push_back(9'h001);
        wait_ticks(1, c);
        check("clr_presc_zero", c, 11);

        // Pause mid-period for 37 clocks
        repeat (4) @(posedge clk);
        #1;
        en = 1'b0;
        pause_ticks = 0;
        repeat (37) begin
            @(negedge clk);
            if (tick) pause_ticks++;
        end
        @(posedge clk);
        #1;
        en = 1'b1;
        check("pause_digits", digits, 8'h01);
        check("pause_no_tick", pause_ticks, 0);
        exp_q.push_back(9'h002);
        wait_ticks(1, c);
        check("pause_resume", c, 7);

        // Async reset between edges while showing 47 with tick high
        do_load(8'h46);
        exp_q.push_back(9'h047);
        wait_ticks(1, c);
        check("pre_reset_latency", c, 11);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_digits", digits, 8'h00);
        check("arst_hex", hex, 14'h2040);
        check("arst_tick", tick, 0);
        check("arst_tc", tc, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
